wb_bus_if: RTL
==============

// Module: wb_bus_if
// PURPOSE
//  - Parametrised Wishbone B4 classic master bridge between one CPU memory port (IF or MEM stage) and the shared bus.
//  - Replaces the direct rom_*/ram_* pins; one instance per port, next to the 5-stage core.
//  - Holds the pipeline through stallreq_o until ack, and keeps read data valid while the pipeline stays stalled.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width; multiple of 8
//  SEL_W        DATA_W/8  byte-select width
//  STALL_W      6   width of pipeline stall vector
//  TIMEOUT_CYC  256 cycles in BUSY before abort; used only with WB_BUS_TIMEOUT_EN; >=2
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  stall_i     in   STALL_W  pipeline stall vector from stall_ctrl
//  flush_i     in   1        pipeline flush; aborts an outstanding access
//  cpu_ce_i    in   1        access request from the stage
//  cpu_we_i    in   1        1 = write, 0 = read
//  cpu_addr_i  in   ADDR_W   access address
//  cpu_sel_i   in   SEL_W    byte enables
//  cpu_data_i  in   DATA_W   write data
//  cpu_data_o  out  DATA_W   read data to the stage
//  stallreq_o  out  1        stall request to stall_ctrl
//  wb_adr_o    out  ADDR_W   Wishbone address
//  wb_dat_o    out  DATA_W   Wishbone write data
//  wb_dat_i    in   DATA_W   Wishbone read data
//  wb_we_o     out  1        Wishbone write enable
//  wb_sel_o    out  SEL_W    Wishbone byte select
//  wb_stb_o    out  1        Wishbone strobe
//  wb_cyc_o    out  1        Wishbone cycle
//  wb_ack_i    in   1        Wishbone acknowledge
//  err_o       out  1        one-cycle bus-timeout pulse; constant 0 without macro
// BEHAVIOUR
//  - Reset: state IDLE. wb_* outputs, rd_buf, timeout counter and err_o are 0.
//  - Registered wb_* outputs. Combinational stallreq_o and cpu_data_o from state, ack, ce and flush.
//  - IDLE:
//    - cpu_ce_i & !flush_i: register adr/dat/we/sel; set stb=cyc=1; go BUSY; stallreq_o=1; cpu_data_o=0.
//    - Otherwise: stallreq_o=0, cpu_data_o=0. A stray wb_ack_i is ignored.
//  - BUSY:
//    - flush_i has priority over ack: clear stb/cyc/we/sel; go IDLE; stallreq_o=0.
//    - wb_ack_i: clear stb/cyc/we/sel. For a read, rd_buf<=wb_dat_i and cpu_data_o=wb_dat_i in the same cycle. stallreq_o=0.
//      Next state is WAIT_STALL if stall_i!=0, else IDLE.
//    - No ack: stallreq_o=1, cpu_data_o=0.
//  - WAIT_STALL:
//    - stallreq_o=0, cpu_data_o=rd_buf.
//    - stall_i==0 -> IDLE. flush_i -> IDLE.
//  - Latency: minimum one bus cycle. A zero-wait slave (ack one cycle after stb) costs one stall cycle per access.
//  - Writes: rd_buf is not updated; cpu_data_o=0 on the ack cycle.
//  - Single outstanding access only. stb and cyc are always equal. No bursts.
//  - Reset mid-access drops cyc/stb asynchronously. A late ack is ignored.
// CONFIGURATION
//  WB_BUS_TIMEOUT_EN defined:
//    - Counter clears on entering BUSY and increments each BUSY cycle without ack.
//    - At TIMEOUT_CYC-1: abort exactly like flush, err_o=1 for one cycle, cpu_data_o=0.
//      Next state follows the ack rule (WAIT_STALL if stall_i!=0, else IDLE); rd_buf=0.
//  WB_BUS_TIMEOUT_EN undefined:
//    - No counter; BUSY waits indefinitely for ack. err_o tied 0.
// STRUCTURE
//  - defines.v: `WbIdle=2'b00, `WbBusy=2'b01, `WbWaitStall=2'b11, `WbStateBus 1:0.
//  - Timeout counter is sub-module wb_timeout_ctr (clear, en, hit), instantiated only under the macro.
//  - Core gets one instance for IF (cpu_we_i=0, sel all-ones) and one for MEM.
//    stallreq_o feeds stall_ctrl as stallreq_from_if / stallreq_from_mem.
// TESTING
//  1 Read, ack after 3 cycles, stall_i=0: cpu_addr_i=32'h100 -> stb/cyc high 3 cycles, stallreq_o high 3 cycles,
//    cpu_data_o=wb_dat_i=32'hDEADBEEF on ack cycle, IDLE next.
//  2 Write, sel=4'b0011, data 32'h0000_1234, zero-wait ack -> wb_we_o=1, wb_sel_o=4'b0011 for 1 cycle,
//    stallreq_o deasserts on ack.
//  3 Read acked while stall_i=6'b000111 for 4 more cycles -> WAIT_STALL, cpu_data_o holds 32'hCAFEF00D each cycle,
//    stallreq_o=0, then IDLE.
//  4 flush_i in BUSY, same cycle as ack -> cyc/stb low next cycle, IDLE, rd_buf unchanged, no data returned.
//  5 rst asserted mid-BUSY, off-edge -> wb_cyc_o/wb_stb_o 0 immediately; ack after release ignored.
//  6 WB_BUS_TIMEOUT_EN, TIMEOUT_CYC=8, no ack -> abort after 8 BUSY cycles, err_o single pulse,
//    stallreq_o 0, cpu_data_o=0.

Source files
------------

// File: rtl/wb_bus_if_pkg.sv
// Shared definitions for the Wishbone classic master bridge (wb_bus_if):
// FSM state encoding and a width helper for the optional bus-timeout
// counter (enabled with WB_BUS_TIMEOUT_EN).
package wb_bus_if_pkg;

  typedef logic [1:0] wb_state_t;

  // Encoding is kept identical to the legacy core defines so waveforms and
  // any external decoding of the state bus stay compatible.
  localparam wb_state_t WB_IDLE       = 2'b00;
  localparam wb_state_t WB_BUSY       = 2'b01;
  localparam wb_state_t WB_WAIT_STALL = 2'b11;

  // Counter width able to hold values 0 .. n-1, never narrower than 1 bit.
  function automatic int wb_cnt_width(input int unsigned n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-timeout counter for wb_bus_if. Only instantiated when the bridge is
// built with WB_BUS_TIMEOUT_EN. Counts BUSY cycles without ack; hit is high
// while the count equals TIMEOUT_CYC-1, i.e. on the last BUSY cycle allowed.
module wb_timeout_ctr
  import wb_bus_if_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic hit
);

  localparam int CNT_W = wb_cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_reg;

  // Restart at every new access, advance on each unacknowledged BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign hit = (count_reg == LAST);

endmodule

// File: rtl/wb_bus_if.sv
// Wishbone B4 classic master bridge for one CPU memory port (IF or MEM).
// One single-beat access at a time; the stage is stalled through stallreq_o
// until ack, and read data is replayed from rd_buf while the pipeline is
// still stalled after the ack.
// Optional feature: define WB_BUS_TIMEOUT_EN to abort accesses that see no
// ack within TIMEOUT_CYC BUSY cycles and pulse err_o.
module wb_bus_if
  import wb_bus_if_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          SEL_W       = DATA_W / 8,
  parameter int          STALL_W     = 6,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               flush_i,
  input  logic               cpu_ce_i,
  input  logic               cpu_we_i,
  input  logic [ADDR_W-1:0]  cpu_addr_i,
  input  logic [SEL_W-1:0]   cpu_sel_i,
  input  logic [DATA_W-1:0]  cpu_data_i,
  output logic [DATA_W-1:0]  cpu_data_o,
  output logic               stallreq_o,
  output logic [ADDR_W-1:0]  wb_adr_o,
  output logic [DATA_W-1:0]  wb_dat_o,
  input  logic [DATA_W-1:0]  wb_dat_i,
  output logic               wb_we_o,
  output logic [SEL_W-1:0]   wb_sel_o,
  output logic               wb_stb_o,
  output logic               wb_cyc_o,
  input  logic               wb_ack_i,
  output logic               err_o
);

  wb_state_t          state_reg, state_next;
  logic [ADDR_W-1:0]  adr_reg;
  logic [DATA_W-1:0]  dat_reg;
  logic               we_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               cyc_reg;
  logic [DATA_W-1:0]  rd_buf_reg;

  logic start;       // new access accepted in IDLE
  logic in_busy;
  logic in_wait;
  logic acked;       // ack taken (flush wins over ack)
  logic busy_wait;   // BUSY cycle with neither ack nor flush
  logic timeout_hit;
  logic timed_out;   // abort by timeout on this cycle
  logic finish;      // access completes by ack or timeout

  assign start     = (state_reg == WB_IDLE) && cpu_ce_i && !flush_i;
  assign in_busy   = (state_reg == WB_BUSY);
  assign in_wait   = (state_reg == WB_WAIT_STALL);
  assign acked     = in_busy && !flush_i && wb_ack_i;
  assign busy_wait = in_busy && !flush_i && !wb_ack_i;
  assign timed_out = busy_wait && timeout_hit;
  assign finish    = acked || timed_out;

`ifdef WB_BUS_TIMEOUT_EN
  logic err_reg;

  wb_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (start),
    .en    (busy_wait),
    .hit   (timeout_hit)
  );

  // One-cycle error pulse following the aborting BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= timed_out;
    end
  end

  assign err_o = err_reg;
`else
  // Without the timeout feature BUSY waits for ack indefinitely.
  assign timeout_hit = 1'b0;
  assign err_o       = 1'b0;
`endif

  // Next-state selection; flush always returns to IDLE, completion parks in
  // WAIT_STALL while the pipeline is still stalled.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WB_IDLE: begin
        if (start) state_next = WB_BUSY;
      end
      WB_BUSY: begin
        if (flush_i) begin
          state_next = WB_IDLE;
        end else if (finish) begin
          state_next = (|stall_i) ? WB_WAIT_STALL : WB_IDLE;
        end
      end
      WB_WAIT_STALL: begin
        if (flush_i || !(|stall_i)) state_next = WB_IDLE;
      end
      default: state_next = WB_IDLE;
    endcase
  end

  // Stage-facing outputs: stall until the access resolves, pass read data
  // through on the ack cycle and replay it from rd_buf while stalled.
  always_comb begin
    stallreq_o = start || (busy_wait && !timeout_hit);
    cpu_data_o = '0;
    if (acked && !we_reg) begin
      cpu_data_o = wb_dat_i;
    end else if (in_wait) begin
      cpu_data_o = rd_buf_reg;
    end
  end

  // State register; reset drops any access in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Registered bus outputs: launch on accept, release on flush/ack/timeout.
  // Address and write data are left as-is after the access ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_reg <= '0;
      dat_reg <= '0;
      we_reg  <= 1'b0;
      sel_reg <= '0;
      cyc_reg <= 1'b0;
    end else if (start) begin
      adr_reg <= cpu_addr_i;
      dat_reg <= cpu_data_i;
      we_reg  <= cpu_we_i;
      sel_reg <= cpu_sel_i;
      cyc_reg <= 1'b1;
    end else if (in_busy && (flush_i || finish)) begin
      we_reg  <= 1'b0;
      sel_reg <= '0;
      cyc_reg <= 1'b0;
    end
  end

  // Read-data holding buffer: captured on a read ack, zeroed on timeout,
  // untouched by writes and flushed accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_buf_reg <= '0;
    end else if (acked && !we_reg) begin
      rd_buf_reg <= wb_dat_i;
    end else if (timed_out) begin
      rd_buf_reg <= '0;
    end
  end

  assign wb_adr_o = adr_reg;
  assign wb_dat_o = dat_reg;
  assign wb_we_o  = we_reg;
  assign wb_sel_o = sel_reg;
  // stb and cyc share one flop so they can never disagree.
  assign wb_stb_o = cyc_reg;
  assign wb_cyc_o = cyc_reg;

endmodule
